fetch_sequencer: RTL
====================

# fetch_sequencer

Controller that decides each cycle whether the fetch stage issues an imem request (`do_fetch`).
- Gates issue on instruction-queue credits and a cap on outstanding imem requests.
- Tracks in-order, variable-latency imem responses.
- After a flush, silently discards responses belonging to the squashed path.
- Sits between the fetch PC/order register block, the imem port and the instruction queue (IQ); also provides a fence/drain handshake for the backend.

## Interface
Parameters:
- `IQ_DEPTH`, default 8: IQ entries; initial credit count.
- `MAX_INFLIGHT`, default 4: maximum outstanding imem requests.

Ports:
- `clk`  in  1  clock; all state on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  backend redirect; fetch loads the target PC this cycle.
- `halt`  in  1  level; suppresses issue while high.
- `fence_req`  in  1  pulse; request fetch drain.
- `imem_resp`  in  1  imem response valid, in request order.
- `iq_deq`  in  1  IQ dequeued one entry; returns one credit.
- `do_fetch`  out  1  issue request this cycle; drives fetch advance and imem_rqst.
- `resp_valid`  out  1  forward this cycle's imem response into the IQ.
- `fence_done`  out  1  one-cycle pulse; drain complete.
- `busy`  out  1  registered; inflight != 0.

## Operation
- Counters (widths `$clog2(N+1)`):
  - `credits`, range 0..IQ_DEPTH.
  - `inflight`, range 0..MAX_INFLIGHT.
  - `drop_cnt`, range 0..MAX_INFLIGHT.
- States: `S_RESET`, `S_RUN`, `S_FENCE`.
  - `S_RESET` -> `S_RUN` unconditionally on the first clock after rst deasserts.
  - `S_RUN` -> `S_FENCE` on `fence_req` (flush in the same cycle takes priority for counters; the state still moves to `S_FENCE`).
  - `S_FENCE` -> `S_RUN` when `inflight==0 && drop_cnt==0`. `fence_done`=1 in that cycle.
- `issue = (state==S_RUN) & !fence_req & !flush & !halt & credits!=0 & inflight!=MAX_INFLIGHT`. `do_fetch = issue`.
- Response handling when `imem_resp`=1:
  - `drop = flush | drop_cnt!=0`; otherwise `resp_valid`=1.
  - A dropped response returns its credit immediately and decrements `drop_cnt` if nonzero.
- Normal update (flush=0):
  - `inflight += issue - imem_resp`.
  - `credits += iq_deq + drop - issue`.
  - `drop_cnt -= (imem_resp & drop_cnt!=0)`.
- Flush cycle:
  - `drop_cnt <= inflight - imem_resp`.
  - `inflight <= inflight - imem_resp`.
  - `credits <= IQ_DEPTH - (inflight - imem_resp)`.
  - `iq_deq` is ignored (the IQ is cleared by the same flush).
- A flush while `drop_cnt`!=0 recomputes `drop_cnt` from `inflight`. This is correct because every in-flight response is stale.
- Protocol errors, caught by bench assertions, with no RTL recovery:
  - `imem_resp` with `inflight==0`.
  - `iq_deq` with `credits==IQ_DEPTH`.

## Timing
- Reset (async assert, sync release):
  - state=`S_RESET`, credits=IQ_DEPTH, inflight=0, drop_cnt=0.
  - All outputs 0.
- `do_fetch` and `resp_valid` are combinational from registered state plus same-cycle `flush`/`halt`/`fence_req`/`imem_resp`. There is no combinational path from `iq_deq` to `do_fetch`.
- A freed slot or credit is usable the cycle after the response or dequeue that frees it; there is no same-cycle bypass.
- First possible `do_fetch` is the 2nd posedge after rst deasserts (one `S_RESET` cycle).
- `do_fetch`=0 in the flush cycle. Fetch may resume at the target PC on the next cycle if counters allow.
- `fence_done` occurs at the earliest in the cycle after `fence_req` when nothing is outstanding.
- rst asserted mid-operation clears everything immediately. Pending responses are the memory side's responsibility (the memory is reset by the same `rst`).

## Structure
- Package `fetch_seq_pkg`:
  - State enum `fetch_seq_state_t`.
  - Width localparams derived from the parameters.
- Sub-module `updown_ctr` (parameterized width/reset value; inc, dec, load, load_val).
  - Instantiated for `credits`, `inflight` and `drop_cnt`.
- FSM and issue/drop logic stay in `fetch_sequencer`.

## Test plan
- **Reset/first issue:** release rst with no stalls.
  - Expect `do_fetch`=0 for one cycle, then 1 every cycle.
  - Expect `inflight` saturating at 4 after 4 issues with no `imem_resp`.
- **Credit exhaustion:** IQ_DEPTH=8, responses 1-cycle, no `iq_deq`.
  - Expect exactly 8 `resp_valid`, then `do_fetch`=0.
  - One `iq_deq` -> exactly one more issue, on the following cycle.
- **Flush with 3 outstanding:** assert flush.
  - Expect `do_fetch`=0 that cycle.
  - The next 3 `imem_resp` give `resp_valid`=0; the 4th (new path) gives `resp_valid`=1.
  - credits = 5 right after the flush, back to 8 after the drops.
- **Flush coincident with `imem_resp`, 2 outstanding:** that response is dropped, `drop_cnt`=1, and only one further response is dropped.
- **Back-to-back flushes** during the drop window: `drop_cnt` tracks `inflight`, and no stale response reaches the IQ.
- **Fence:** `fence_req` with 2 outstanding.
  - Expect no issue.
  - `fence_done` pulses in the cycle `inflight` reaches 0, then issue resumes.
  - Repeat with `halt` held high: `fence_done` still pulses, and `do_fetch` stays 0 until `halt` drops.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and width helpers for the fetch sequencer and its counters.
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_FENCE
  } fetch_seq_state_t;

  localparam int IQ_DEPTH_DEF     = 8;
  localparam int MAX_INFLIGHT_DEF = 4;

  // Bits needed to hold a count in 0..n inclusive.
  function automatic int ctr_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/handshake bundle between the fetch sequencer and its neighbours
// (fetch PC block, imem port, instruction queue, backend).
interface fetch_sequencer_if;
  logic flush;
  logic halt;
  logic fence_req;
  logic imem_resp;
  logic iq_deq;
  logic do_fetch;
  logic resp_valid;
  logic fence_done;
  logic busy;

  modport master (
    output flush, halt, fence_req, imem_resp, iq_deq,
    input  do_fetch, resp_valid, fence_done, busy
  );

  modport slave (
    input  flush, halt, fence_req, imem_resp, iq_deq,
    output do_fetch, resp_valid, fence_done, busy
  );
endinterface

// File: rtl/updown_ctr.sv
// Loadable up/down counter; load wins over the inc/dec step.
module updown_ctr #(
  parameter int             W       = 4,
  parameter int             STEP_W  = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STEP_W-1:0] inc,
  input  logic [STEP_W-1:0] dec,
  input  logic              load,
  input  logic [W-1:0]      load_val,
  output logic [W-1:0]      q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RST_VAL;
    else if (load) q <= load_val;
    else           q <= q + W'(inc) - W'(dec);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Decides each cycle whether fetch issues an imem request, tracks in-flight
// responses and silently drops those belonging to a squashed path.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int IQ_DEPTH     = IQ_DEPTH_DEF,
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEF
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);

  localparam int                CRED_W    = ctr_w(IQ_DEPTH);
  localparam int                INFL_W    = ctr_w(MAX_INFLIGHT);
  localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(IQ_DEPTH);
  localparam logic [INFL_W-1:0] INFL_MAX  = INFL_W'(MAX_INFLIGHT);

  fetch_seq_state_t  state_q;
  logic [CRED_W-1:0] credits;
  logic [INFL_W-1:0] inflight;
  logic [INFL_W-1:0] drop_cnt;
  logic [INFL_W-1:0] infl_after_resp;
  logic [1:0]        cred_inc;
  logic              issue;
  logic              drop;
  logic              dropping;
  logic              fence_done_w;

  assign dropping        = drop_cnt != '0;
  assign issue           = (state_q == S_RUN) & ~bus.fence_req & ~bus.flush & ~bus.halt
                         & (credits != '0) & (inflight != INFL_MAX);
  assign drop            = bus.imem_resp & (bus.flush | dropping);
  assign infl_after_resp = inflight - INFL_W'(bus.imem_resp);
  assign fence_done_w    = (state_q == S_FENCE) & (inflight == '0) & ~dropping;

  assign bus.do_fetch   = issue;
  assign bus.resp_valid = bus.imem_resp & ~drop;
  assign bus.fence_done = fence_done_w;
  assign bus.busy       = inflight != '0;

  // On flush the IQ is cleared, so dequeues are meaningless and every
  // request still outstanding owns a credit until its stale response drains.
  assign cred_inc = bus.flush ? 2'd0 : 2'(bus.iq_deq) + 2'(drop);

  updown_ctr #(.W(CRED_W), .STEP_W(2), .RST_VAL(CRED_FULL)) u_credits (
    .clk      (clk),
    .rst      (rst),
    .inc      (cred_inc),
    .dec      (2'(issue)),
    .load     (bus.flush),
    .load_val (CRED_FULL - CRED_W'(infl_after_resp)),
    .q        (credits)
  );

  // issue is already 0 during a flush, so no load is needed here.
  updown_ctr #(.W(INFL_W), .STEP_W(1), .RST_VAL('0)) u_inflight (
    .clk      (clk),
    .rst      (rst),
    .inc      (issue),
    .dec      (bus.imem_resp),
    .load     (1'b0),
    .load_val ('0),
    .q        (inflight)
  );

  updown_ctr #(.W(INFL_W), .STEP_W(1), .RST_VAL('0)) u_drop_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b0),
    .dec      (bus.imem_resp & dropping),
    .load     (bus.flush),
    .load_val (infl_after_resp),
    .q        (drop_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
    end else begin
      case (state_q)
        S_RESET: state_q <= S_RUN;
        S_RUN:   if (bus.fence_req) state_q <= S_FENCE;
        S_FENCE: if (fence_done_w)  state_q <= S_RUN;
        default: state_q <= S_RESET;
      endcase
    end
  end

endmodule
